// File: rtl/minibyte_cu.sv
// Minibyte control unit: two-byte fetch/fetch/execute sequencer that drives
// the ALU operands and opcode and holds PC, A, IR, ARG and the Z/N flags.
module minibyte_cu (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_in,
  output logic [7:0] mem_addr_out,
  input  logic [7:0] mem_data_in,
  output logic [7:0] mem_data_out,
  output logic       mem_we_out,
  output logic [7:0] alu_a_out,
  output logic [7:0] alu_b_out,
  output logic [2:0] alu_op_out,
  input  logic [7:0] alu_res_in,
  input  logic       alu_z_in,
  input  logic       alu_n_in,
  output logic [7:0] acc_out,
  output logic [7:0] pc_out,
  output logic [1:0] state_out,
  output logic       halted_out
);

  localparam int unsigned DW = 8;
  localparam int unsigned OPW = 3;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ALUI = 4'h4;
  localparam logic [3:0] OP_ALUM = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JN   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [OPW-1:0] ALU_PASS_B = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH_OP  = 2'd0,
    S_FETCH_ARG = 2'd1,
    S_EXEC      = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] pc;
  logic [DW-1:0] acc;
  logic [DW-1:0] ir;
  logic [DW-1:0] arg;
  logic          z;
  logic          n;

  logic [3:0] opc;
  logic       is_alu_op;
  logic       uses_mem_b;
  logic       unused_ir_bit3;

  assign opc            = ir[7:4];
  assign unused_ir_bit3 = ir[3];
  assign is_alu_op      = (opc == OP_ALUI) || (opc == OP_ALUM);
  assign uses_mem_b     = (opc == OP_LDA) || (opc == OP_ALUM);

  // Memory and ALU drive decode straight from the held registers
  assign mem_addr_out = (state == S_EXEC) ? arg : pc;
  assign mem_data_out = acc;
  assign mem_we_out   = (state == S_EXEC) && (opc == OP_STA) && run_in && !rst;
  assign alu_a_out    = acc;
  assign alu_b_out    = uses_mem_b ? mem_data_in : arg;
  assign alu_op_out   = is_alu_op ? ir[2:0] : ALU_PASS_B;
  assign acc_out      = acc;
  assign pc_out       = pc;
  assign state_out    = 2'(state);
  assign halted_out   = (state == S_HALT);

  // Sequencer and architectural registers; run_in low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH_OP;
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
      arg   <= '0;
      z     <= 1'b0;
      n     <= 1'b0;
    end else if (run_in) begin
      unique case (state)
        S_FETCH_OP: begin
          ir    <= mem_data_in;
          pc    <= pc + 8'd1;
          state <= S_FETCH_ARG;
        end
        S_FETCH_ARG: begin
          arg   <= mem_data_in;
          pc    <= pc + 8'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH_OP;
          case (opc)
            OP_LDI, OP_LDA, OP_ALUI, OP_ALUM: begin
              acc <= alu_res_in;
              z   <= alu_z_in;
              n   <= alu_n_in;
            end
            OP_JMP:  pc <= arg;
            OP_JZ:   if (z) pc <= arg;
            OP_JN:   if (n) pc <= arg;
            OP_HALT: state <= S_HALT;
            default: ;
          endcase
        end
        S_HALT: ;
        default: state <= S_FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_cu.sv
// Scoreboard bench for minibyte_cu: behavioural memory and ALU around the DUT,
// directed programs push expected writes/halts/snapshots for a negedge monitor.
module tb_minibyte_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_in = 1'b0;
  logic [7:0] mem_addr_out;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       mem_we_out;
  logic [7:0] alu_a_out;
  logic [7:0] alu_b_out;
  logic [2:0] alu_op_out;
  logic [7:0] alu_res_in;
  logic       alu_z_in;
  logic       alu_n_in;
  logic [7:0] acc_out;
  logic [7:0] pc_out;
  logic [1:0] state_out;
  logic       halted_out;

  minibyte_cu dut (
    .clk(clk), .rst(rst), .run_in(run_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_we_out(mem_we_out),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
    .alu_res_in(alu_res_in), .alu_z_in(alu_z_in), .alu_n_in(alu_n_in),
    .acc_out(acc_out), .pc_out(pc_out), .state_out(state_out),
    .halted_out(halted_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 pass B
  always_comb begin
    case (alu_op_out)
      3'd0:    alu_res_in = alu_a_out + alu_b_out;
      3'd1:    alu_res_in = alu_a_out - alu_b_out;
      3'd2:    alu_res_in = alu_a_out & alu_b_out;
      3'd3:    alu_res_in = alu_a_out | alu_b_out;
      3'd4:    alu_res_in = alu_a_out ^ alu_b_out;
      3'd5:    alu_res_in = {alu_a_out[6:0], 1'b0};
      3'd6:    alu_res_in = {1'b0, alu_a_out[7:1]};
      default: alu_res_in = alu_b_out;
    endcase
  end
  assign alu_z_in = (alu_res_in == 8'h00);
  assign alu_n_in = alu_res_in[7];

  // Memory: img is the program image, copied into mem while mem_load is set
  logic [7:0] img [256];
  logic [7:0] mem [256];
  logic       mem_load = 1'b0;
  assign mem_data_in = mem[mem_addr_out];

  always @(posedge clk) begin
    if (mem_load) mem = img;
    else if (mem_we_out) mem[mem_addr_out] = mem_data_out;
  end

  typedef enum logic [1:0] {EV_WR, EV_HALT, EV_SNAP} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] pc;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic sample_req = 1'b0;
  logic prev_halt = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_exp(input ev_t k, output exp_t e, output bit ok);
    ok = 1'b0;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", k, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", 8'(e.kind), 8'(k));
      ok = (e.kind == k);
    end
  endtask

  // Monitor: compares DUT-presented events against the queue head
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (mem_we_out) begin
      pop_exp(EV_WR, e, ok);
      if (ok) begin
        chk("wr_addr", mem_addr_out, e.addr);
        chk("wr_data", mem_data_out, e.data);
      end
    end
    if (halted_out && !prev_halt) begin
      pop_exp(EV_HALT, e, ok);
      if (ok) begin
        chk("halt_acc", acc_out, e.data);
        chk("halt_pc", pc_out, e.pc);
      end
    end
    if (sample_req) begin
      pop_exp(EV_SNAP, e, ok);
      if (ok) begin
        chk("snap_pc", pc_out, e.pc);
        chk("snap_acc", acc_out, e.data);
        chk("snap_state", 8'(state_out), 8'(e.st));
        chk("snap_addr", mem_addr_out, e.addr);
        chk("snap_halted", 8'(halted_out), (e.st == 2'd3) ? 8'd1 : 8'd0);
        chk("snap_we", 8'(mem_we_out), 8'd0);
      end
    end
    prev_halt <= halted_out;
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    q.push_back('{kind: EV_WR, addr: a, data: d, pc: 8'h00, st: 2'd0});
  endtask

  task automatic exp_halt(input logic [7:0] p, input logic [7:0] acc);
    q.push_back('{kind: EV_HALT, addr: 8'h00, data: acc, pc: p, st: 2'd3});
  endtask

  task automatic snap(input logic [7:0] p, input logic [7:0] acc,
                      input logic [1:0] st, input logic [7:0] a);
    q.push_back('{kind: EV_SNAP, addr: a, data: acc, pc: p, st: st});
    sample_req = 1'b1;
    @(negedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic clear_img();
    foreach (img[i]) img[i] = 8'h00;
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] op, input logic [7:0] ar);
    img[a] = op;
    img[8'(a + 8'd1)] = ar;
  endtask

  task automatic do_reset(input bit load);
    rst = 1'b1;
    run_in = 1'b0;
    mem_load = load;
    step(1);
    mem_load = 1'b0;
    step(1);
  endtask

  task automatic start();
    rst = 1'b0;
    run_in = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, input string name);
    int k = 0;
    while (!halted_out && k < budget) begin
      step(1);
      k++;
    end
    n_cmp++;
    if (!halted_out) begin
      n_bad++;
      $display("FAIL %s_timeout: halted=0 after %0d cycles, expected halt", name, budget);
    end
    step(2);
  endtask

  initial begin
    // P1: LDI 5; SUB 3; HALT
    clear_img();
    put(8'h00, 8'h10, 8'h05);
    put(8'h02, 8'h41, 8'h03);
    put(8'h04, 8'hF0, 8'h00);
    do_reset(1'b1);
    snap(8'h00, 8'h00, 2'd0, 8'h00);
    start();
    step(8);
    snap(8'h06, 8'h02, 2'd2, 8'h00);
    exp_halt(8'h06, 8'h02);
    step(1);
    snap(8'h06, 8'h02, 2'd3, 8'h06);
    step(3);
    snap(8'h06, 8'h02, 2'd3, 8'h06);
    // Reset while halted
    rst = 1'b1;
    step(1);
    snap(8'h00, 8'h00, 2'd0, 8'h00);

    // P2: LDI 80; STA 20; LDI 0; LDA 20; JN 10 (taken) -> HALT at 10
    clear_img();
    put(8'h00, 8'h10, 8'h80);
    put(8'h02, 8'h30, 8'h20);
    put(8'h04, 8'h10, 8'h00);
    put(8'h06, 8'h20, 8'h20);
    put(8'h08, 8'h80, 8'h10);
    put(8'h0A, 8'h10, 8'h11);
    put(8'h0C, 8'hF0, 8'h00);
    put(8'h10, 8'hF0, 8'h00);
    do_reset(1'b1);
    exp_wr(8'h20, 8'h80);
    exp_halt(8'h12, 8'h80);
    start();
    run_to_halt(40, "p2");

    // P3: LDI 1; SUB 1; JZ 10 (taken)
    clear_img();
    put(8'h00, 8'h10, 8'h01);
    put(8'h02, 8'h41, 8'h01);
    put(8'h04, 8'h70, 8'h10);
    put(8'h06, 8'h10, 8'hFF);
    put(8'h08, 8'hF0, 8'h00);
    put(8'h10, 8'hF0, 8'h00);
    do_reset(1'b1);
    exp_halt(8'h12, 8'h00);
    start();
    run_to_halt(30, "p3_taken");

    // P3b: first immediate 2, branch falls through to LDI FF
    img[8'h01] = 8'h02;
    do_reset(1'b1);
    exp_halt(8'h0A, 8'hFF);
    start();
    run_to_halt(30, "p3_not_taken");

    // P4: LDI 5A; STA 30; HALT, frozen for 5 cycles in FETCH_ARG of STA
    clear_img();
    put(8'h00, 8'h10, 8'h5A);
    put(8'h02, 8'h30, 8'h30);
    put(8'h04, 8'hF0, 8'h00);
    do_reset(1'b1);
    start();
    step(4);
    run_in = 1'b0;
    step(5);
    snap(8'h03, 8'h5A, 2'd1, 8'h03);
    exp_wr(8'h30, 8'h5A);
    exp_halt(8'h06, 8'h5A);
    run_in = 1'b1;
    run_to_halt(20, "p4");

    // P5: reset lands during EXEC of STA, write must be suppressed
    do_reset(1'b1);
    start();
    step(5);
    rst = 1'b1;
    step(1);
    snap(8'h00, 8'h00, 2'd0, 8'h00);
    chk("sta_aborted_mem30", mem[8'h30], 8'h00);

    // P6: JMP FE; LDI 33 at FE; opcode fetch wraps to 00
    clear_img();
    put(8'h00, 8'h60, 8'hFE);
    put(8'hFE, 8'h10, 8'h33);
    do_reset(1'b1);
    start();
    step(4);
    snap(8'hFF, 8'h00, 2'd1, 8'hFF);
    step(2);
    snap(8'h00, 8'h33, 2'd0, 8'h00);

    // P7: LDI 0F; ADD mem[40]=21; AND F0; STA 41; NOP-class 0x9; HALT
    clear_img();
    put(8'h00, 8'h10, 8'h0F);
    put(8'h02, 8'h50, 8'h40);
    put(8'h04, 8'h42, 8'hF0);
    put(8'h06, 8'h30, 8'h41);
    put(8'h08, 8'h90, 8'h77);
    put(8'h0A, 8'hF0, 8'h00);
    img[8'h40] = 8'h21;
    do_reset(1'b1);
    exp_wr(8'h41, 8'h30);
    exp_halt(8'h0C, 8'h30);
    start();
    run_to_halt(40, "p7");

    step(2);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
